// File: rtl/inert_seq_ctrl.sv
// Sequencer between the SPI master and the pitch integrator: configures the
// inertial sensor after reset, then reads pitch-rate / Z-accel byte pairs per data-ready.
module inert_seq_ctrl #(
    parameter int INIT_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG0,
        CFG1,
        CFG2,
        CFG3,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH
    } state_t;

    state_t                  state_q, state_d;
    logic [INIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    int_ff1_q, int_s_q;
    logic                    wrt_q, wrt_d;
    logic [15:0]             cmd_q, cmd_d;
    logic                    vld_q, vld_d;
    logic [15:0]             ptch_q, ptch_d;
    logic [15:0]             az_q, az_d;
    logic [7:0]              pl_q, pl_d;
    logic [7:0]              ph_q, ph_d;
    logic [7:0]              al_q, al_d;
    logic                    unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        ptch_d  = ptch_q;
        az_d    = az_q;
        pl_d    = pl_q;
        ph_d    = ph_q;
        al_d    = al_q;

        // Every done-driven transition issues the next command on the same edge.
        case (state_q)
            INIT_WAIT: begin
                cnt_d = cnt_q + INIT_CNT_W'(1);
                if (&cnt_q) begin
                    state_d = CFG0;
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h0D02;
                end
            end
            CFG0: if (done) begin
                state_d = CFG1;
                wrt_d   = 1'b1;
                cmd_d   = 16'h1053;
            end
            CFG1: if (done) begin
                state_d = CFG2;
                wrt_d   = 1'b1;
                cmd_d   = 16'h1150;
            end
            CFG2: if (done) begin
                state_d = CFG3;
                wrt_d   = 1'b1;
                cmd_d   = 16'h1460;
            end
            CFG3: if (done) begin
                state_d = IDLE;
            end
            IDLE: if (int_s_q) begin
                state_d = RD_PL;
                wrt_d   = 1'b1;
                cmd_d   = 16'hA200;
            end
            RD_PL: if (done) begin
                pl_d    = rd_data[7:0];
                state_d = RD_PH;
                wrt_d   = 1'b1;
                cmd_d   = 16'hA300;
            end
            RD_PH: if (done) begin
                ph_d    = rd_data[7:0];
                state_d = RD_AL;
                wrt_d   = 1'b1;
                cmd_d   = 16'hAC00;
            end
            RD_AL: if (done) begin
                al_d    = rd_data[7:0];
                state_d = RD_AH;
                wrt_d   = 1'b1;
                cmd_d   = 16'hAD00;
            end
            RD_AH: if (done) begin
                ptch_d  = {ph_q, pl_q};
                az_d    = {rd_data[7:0], al_q};
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT_WAIT;
            cnt_q     <= '0;
            int_ff1_q <= 1'b0;
            int_s_q   <= 1'b0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            vld_q     <= 1'b0;
            ptch_q    <= 16'h0000;
            az_q      <= 16'h0000;
            pl_q      <= 8'h00;
            ph_q      <= 8'h00;
            al_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_ff1_q <= INT;
            int_s_q   <= int_ff1_q;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            vld_q     <= vld_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            pl_q      <= pl_d;
            ph_q      <= ph_d;
            al_q      <= al_d;
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_seq_ctrl.sv
// Scoreboard bench for inert_seq_ctrl: acts as the SPI master's done side and
// checks command order, handshake timing and assembled sample words.
module tb_inert_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    typedef struct {
        logic [15:0] p;
        logic [15:0] a;
    } vld_exp_t;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [15:0] cmdQ[$];
    vld_exp_t    vldQ[$];
    vld_exp_t    monExp;
    logic [15:0] lastP = 16'h0000;
    logic [15:0] lastA = 16'h0000;
    int          n;

    inert_seq_ctrl #(.INIT_CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts negedges until wrt is seen (0 if already high), bounded.
    task automatic waitWrt(output int cnt);
        cnt = 0;
        while (wrt !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (wrt !== 1'b1) checkOutput("wrt_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int delay, input logic [7:0] rdByte, input string tag);
        int          w;
        int          bad;
        logic [15:0] held;
        logic [7:0]  hi;
        waitWrt(w);
        if (cmdQ.size() == 0) checkOutput({tag, "_unexpected_wrt"}, 1, 0);
        else checkOutput({tag, "_cmd"}, cmd, cmdQ.pop_front());
        held = cmd;
        bad  = 0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            if (wrt !== 1'b0 || cmd !== held) bad++;
        end
        checkOutput({tag, "_hold"}, bad, 0);
        hi      = 8'($urandom_range(0, 255));
        done    = 1'b1;
        rd_data = {hi, rdByte};
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
    endtask

    task automatic quietCheck(input int cycles, input string tag);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wrt !== 1'b0 || vld !== 1'b0) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    task automatic configSeq(input string tag);
        cmdQ.push_back(16'h0D02);
        cmdQ.push_back(16'h1053);
        cmdQ.push_back(16'h1150);
        cmdQ.push_back(16'h1460);
        for (int i = 0; i < 4; i++) applyStimulus(3, 8'($urandom_range(0, 255)), tag);
    endtask

    task automatic readSeq(input logic [7:0] pl, input logic [7:0] ph, input logic [7:0] al,
                           input logic [7:0] ah, input int delay, input string tag);
        vld_exp_t e;
        e.p = {ph, pl};
        e.a = {ah, al};
        cmdQ.push_back(16'hA200);
        cmdQ.push_back(16'hA300);
        cmdQ.push_back(16'hAC00);
        cmdQ.push_back(16'hAD00);
        vldQ.push_back(e);
        applyStimulus(delay, pl, {tag, "_pl"});
        applyStimulus(delay, ph, {tag, "_ph"});
        applyStimulus(delay, al, {tag, "_al"});
        applyStimulus(delay, ah, {tag, "_ah"});
        checkOutput({tag, "_vld_timing"}, vld, 1);
        lastP = e.p;
        lastA = e.a;
    endtask

    // Each vld pulse must match the oldest outstanding expected sample.
    always @(negedge clk) begin
        if (vld === 1'b1) begin
            if (vldQ.size() == 0) checkOutput("vld_unexpected", 1, 0);
            else begin
                monExp = vldQ.pop_front();
                checkOutput("ptch_rt", ptch_rt, monExp.p);
                checkOutput("AZ", AZ, monExp.a);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        INT     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("rst_wrt", wrt, 0);
        checkOutput("rst_cmd", cmd, 0);
        checkOutput("rst_vld", vld, 0);
        checkOutput("rst_ptch", ptch_rt, 0);
        checkOutput("rst_az", AZ, 0);

        rst = 1'b0;
        waitWrt(n);
        checkOutput("init_latency", n, 16);
        configSeq("cfg");
        quietCheck(12, "idle_after_cfg");

        INT = 1'b1;
        waitWrt(n);
        checkOutput("rd_latency", n, 3);
        INT = 1'b0;
        readSeq(8'h34, 8'h12, 8'hCD, 8'hAB, 3, "rd1");
        quietCheck(8, "idle_after_rd1");

        INT = 1'b1;
        waitWrt(n);
        INT = 1'b0;
        readSeq(8'h5A, 8'h80, 8'h01, 8'h7F, 1, "fast");

        INT = 1'b1;
        waitWrt(n);
        INT = 1'b0;
        readSeq(8'hE3, 8'h0F, 8'h99, 8'hC4, 40, "slow");

        @(negedge clk);
        done    = 1'b1;
        rd_data = 16'h00EE;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
        quietCheck(8, "spurious_done");
        checkOutput("spur_ptch", ptch_rt, lastP);
        checkOutput("spur_az", AZ, lastA);

        INT = 1'b1;
        waitWrt(n);
        readSeq(8'h50, 8'h00, 8'h60, 8'hFF, 2, "b2b1");
        INT = 1'b0;
        waitWrt(n);
        checkOutput("b2b_gap", n, 1);
        readSeq(8'h51, 8'h00, 8'h61, 8'hFF, 2, "b2b2");
        quietCheck(10, "b2b_end");

        INT = 1'b1;
        waitWrt(n);
        INT = 1'b0;
        readSeq(8'h34, 8'h12, 8'hCD, 8'hAB, 2, "rd2");

        INT = 1'b1;
        cmdQ.push_back(16'hA200);
        applyStimulus(2, 8'h77, "rst_pl");
        INT = 1'b0;
        waitWrt(n);
        checkOutput("rst_ph_cmd", cmd, 16'hA300);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wrt", wrt, 0);
        checkOutput("midrst_cmd", cmd, 0);
        checkOutput("midrst_vld", vld, 0);
        checkOutput("midrst_ptch", ptch_rt, 0);
        checkOutput("midrst_az", AZ, 0);
        done    = 1'b1;
        rd_data = 16'h00AA;
        @(negedge clk);
        done    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
        waitWrt(n);
        checkOutput("reinit_latency", n + 2, 16);
        configSeq("recfg");
        quietCheck(12, "idle_after_recfg");
        checkOutput("reinit_ptch", ptch_rt, 0);
        checkOutput("reinit_az", AZ, 0);
        checkOutput("cmdq_empty", cmdQ.size(), 0);
        checkOutput("vldq_empty", vldQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
